// File: rtl/bit_scan_pkg.sv
// -----------------------------------------------------------------------------
// bit_scan_pkg
// Shared definitions for bit_scan_encoder and its selector:
//   state_t          - controller states (IDLE, SCAN, EMPTY)
//   MODE_FIXED/RR    - values of the MODE parameter
//   min_idx_width()  - narrowest index able to hold 0..n, where n itself
//                      is the "empty vector" code
// -----------------------------------------------------------------------------
package bit_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        EMPTY = 2'd2
    } state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int min_idx_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_scan_encoder_select.sv
// -----------------------------------------------------------------------------
// rotate_priority_select
// Combinational "first set bit at or above start, wrapping" selector.
// With start tied to zero it degenerates into a plain lowest-set-bit encoder.
// Ports:
//   vec   [WIDTH]  candidate bits
//   start [IDX_W]  search origin, must be < WIDTH
//   idx   [IDX_W]  absolute index of the chosen bit (0 when none found)
//   found          at least one bit of vec is set
//   grant [WIDTH]  one-hot mask of the chosen bit (all zero when none)
// -----------------------------------------------------------------------------
module rotate_priority_select #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found,
    output logic [WIDTH-1:0] grant
);

    logic [WIDTH-1:0] w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    // Rotate right by start: bit i of w_rot is vec[(i + start) mod WIDTH].
    // Shifting the doubled vector avoids a variable modulo.
    assign w_rot = WIDTH'({vec, vec} >> start);

    // Lowest set bit of the rotated vector is the offset from start.
    always_comb begin
        found = 1'b0;
        w_off = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                found = 1'b1;
                w_off = IDX_W'(i);
            end
        end
    end

    // Undo the rotation; start and offset are both < WIDTH so one
    // conditional subtract is enough.
    always_comb begin
        w_sum = {1'b0, start} + {1'b0, w_off};
        if (w_sum >= (IDX_W + 1)'(WIDTH)) begin
            w_sum = w_sum - (IDX_W + 1)'(WIDTH);
        end
        idx = found ? w_sum[IDX_W-1:0] : '0;
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_grant
        assign grant[gi] = found && (idx == IDX_W'(gi));
    end

endmodule

// File: rtl/bit_scan_encoder.sv
// -----------------------------------------------------------------------------
// bit_scan_encoder
// Accepts a request vector in IDLE and streams the index of every set bit,
// one per cycle, over a valid/ready interface. MODE 0 walks from bit 0
// upward; MODE 1 starts at a rotating pointer that survives across vectors.
// An all-zero vector yields a single beat with out_idx = IN_SIZE, out_none.
// Optional build macro: BIT_SCAN_COUNT_EN adds out_remaining (bits still
// pending in SCAN, including the current beat).
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_ready     vector handshake (ready only in IDLE)
//   in_vec   [IN_SIZE]    request vector
//   out_valid/out_ready   index handshake
//   out_idx  [OUT_SIZE]   selected index, IN_SIZE for an empty vector
//   out_last              final beat of the current vector
//   out_none              vector was all zero
//   out_remaining         (BIT_SCAN_COUNT_EN only) popcount of pending
// -----------------------------------------------------------------------------
module bit_scan_encoder
    import bit_scan_pkg::*;
#(
    parameter int IN_SIZE  = 8,
    parameter int OUT_SIZE = 4,
    parameter int MODE     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_SIZE-1:0]  in_vec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_SIZE-1:0] out_idx,
    output logic                out_last,
`ifdef BIT_SCAN_COUNT_EN
    output logic [OUT_SIZE-1:0] out_remaining,
`endif
    output logic                out_none
);

    if (IN_SIZE < 2) begin : g_chk_in
        $error("bit_scan_encoder: IN_SIZE must be at least 2");
    end
    if (OUT_SIZE < min_idx_width(IN_SIZE)) begin : g_chk_out
        $error("bit_scan_encoder: OUT_SIZE too narrow to encode IN_SIZE");
    end

    state_t              r_state;
    logic [IN_SIZE-1:0]  r_pending;
    logic [OUT_SIZE-1:0] w_start;
    logic [OUT_SIZE-1:0] w_sel_idx;
    logic                w_found;
    logic [IN_SIZE-1:0]  w_grant;
    logic                w_one_left;
    logic                w_take;

    rotate_priority_select #(
        .WIDTH (IN_SIZE),
        .IDX_W (OUT_SIZE)
    ) u_sel (
        .vec   (r_pending),
        .start (w_start),
        .idx   (w_sel_idx),
        .found (w_found),
        .grant (w_grant)
    );

    // Clearing the lowest set bit leaves zero only if one bit was set.
    assign w_one_left = ((r_pending & (r_pending - IN_SIZE'(1))) == '0);
    assign w_take     = (r_state == SCAN) && out_ready && w_found;

    if (MODE == MODE_RR) begin : g_rr
        logic [OUT_SIZE-1:0] r_rr_ptr;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rr_ptr <= '0;
            end else if (w_take) begin
                r_rr_ptr <= (w_sel_idx == OUT_SIZE'(IN_SIZE - 1)) ? '0
                                                                  : w_sel_idx + 1'b1;
            end
        end

        assign w_start = r_rr_ptr;
    end else begin : g_fixed
        assign w_start = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_pending <= in_vec;
                        r_state   <= (in_vec != '0) ? SCAN : EMPTY;
                    end
                end
                SCAN: begin
                    if (w_take) begin
                        r_pending <= r_pending & ~w_grant;
                        if (w_one_left) begin
                            r_state <= IDLE;
                        end
                    end
                end
                EMPTY: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, so nothing on in_* can
    // reach out_* in the same cycle.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        case (r_state)
            SCAN: begin
                out_valid = 1'b1;
                out_idx   = w_sel_idx;
                out_last  = w_one_left;
            end
            EMPTY: begin
                out_valid = 1'b1;
                out_idx   = OUT_SIZE'(IN_SIZE);
                out_last  = 1'b1;
                out_none  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef BIT_SCAN_COUNT_EN
    logic [OUT_SIZE-1:0] w_popcount;

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            w_popcount = w_popcount + OUT_SIZE'(r_pending[i]);
        end
        out_remaining = (r_state == SCAN) ? w_popcount : '0;
    end
`endif

endmodule

// File: tb/tb_bit_scan_encoder.sv
module tb_bit_scan_encoder;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [N-1:0] in_vec = '0;
    logic         out_ready = 1'b1;
    logic         in_ready0, in_ready1;
    logic         ov0, ov1, ol0, ol1, on0, on1;
    logic [W-1:0] oi0, oi1;
    logic [W-1:0] orem0, orem1;

    always #5 clk = ~clk;

    bit_scan_encoder #(.IN_SIZE(N), .OUT_SIZE(W), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_vec(in_vec), .out_valid(ov0), .out_ready(out_ready),
        .out_idx(oi0), .out_last(ol0),
`ifdef BIT_SCAN_COUNT_EN
        .out_remaining(orem0),
`endif
        .out_none(on0)
    );

    bit_scan_encoder #(.IN_SIZE(N), .OUT_SIZE(W), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_vec(in_vec), .out_valid(ov1), .out_ready(out_ready),
        .out_idx(oi1), .out_last(ol1),
`ifdef BIT_SCAN_COUNT_EN
        .out_remaining(orem1),
`endif
        .out_none(on1)
    );

`ifndef BIT_SCAN_COUNT_EN
    assign orem0 = '0;
    assign orem1 = '0;
`endif

    typedef struct packed {
        logic [W-1:0] idx;
        logic         last;
        logic         none;
        logic [W-1:0] rem;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    model_ptr = 0;   // round-robin pointer of the reference model
    int    ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: list the set bits in emission order for each mode.
    task automatic push_expected(input logic [N-1:0] vec);
        int    ord0[$];
        int    ord1[$];
        beat_t b;
        if (vec == '0) begin
            b.idx = W'(N); b.last = 1'b1; b.none = 1'b1; b.rem = '0;
            q0.push_back(b);
            q1.push_back(b);
            return;
        end
        for (int i = 0; i < N; i++) if (vec[i]) ord0.push_back(i);
        for (int k = 0; k < N; k++) if (vec[(model_ptr + k) % N]) ord1.push_back((model_ptr + k) % N);
        model_ptr = (ord1[ord1.size() - 1] + 1) % N;
        for (int j = 0; j < ord0.size(); j++) begin
            b.none = 1'b0;
            b.last = (j == ord0.size() - 1);
            b.rem  = W'(ord0.size() - j);
            b.idx  = W'(ord0[j]);
            q0.push_back(b);
            b.idx  = W'(ord1[j]);
            q1.push_back(b);
        end
    endtask

    task automatic mon(input int w, input logic v, input logic inr, input logic [W-1:0] idx,
                       input logic last, input logic none, input logic [W-1:0] rem);
        int    qs;
        beat_t e;
        qs = (w == 0) ? q0.size() : q1.size();
        chk($sformatf("dut%0d in_ready", w), int'(inr), int'(qs == 0));
        chk($sformatf("dut%0d out_valid", w), int'(v), int'(qs > 0));
        if (v && qs > 0) begin
            e = (w == 0) ? q0[0] : q1[0];
            chk($sformatf("dut%0d out_idx", w), int'(idx), int'(e.idx));
            chk($sformatf("dut%0d out_last", w), int'(last), int'(e.last));
            chk($sformatf("dut%0d out_none", w), int'(none), int'(e.none));
`ifdef BIT_SCAN_COUNT_EN
            chk($sformatf("dut%0d out_remaining", w), int'(rem), int'(e.rem));
`endif
            if (out_ready) begin
                if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                $display("dut%0d beat idx=%0d last=%0d none=%0d rem=%0d", w, idx, last, none, rem);
            end
        end else if (!v) begin
            chk($sformatf("dut%0d idle_idx", w), int'(idx), 0);
            chk($sformatf("dut%0d idle_last", w), int'(last), 0);
            chk($sformatf("dut%0d idle_none", w), int'(none), 0);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            mon(0, ov0, in_ready0, oi0, ol0, on0, orem0);
            mon(1, ov1, in_ready1, oi1, ol1, on1, orem1);
        end
    end

    // Consumer back-pressure generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = ($urandom % 4) != 0;
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [N-1:0] vec);
        int guard = 0;
        @(negedge clk);
        while (!(in_ready0 && in_ready1)) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                chk("send_timeout", 0, 1);
                return;
            end
        end
        in_valid = 1'b1;
        in_vec   = vec;
        $display("send vec=%02h", vec);
        @(posedge clk);
        push_expected(vec);
        #1;
        in_valid = 1'b0;
        in_vec   = N'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while (q0.size() != 0 || q1.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                chk("drain_timeout", 0, 1);
                q0.delete();
                q1.delete();
                return;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rv;
        repeat (2) @(posedge clk);
        #2;
        chk("reset out_valid0", int'(ov0), 0);
        chk("reset out_valid1", int'(ov1), 0);
        chk("reset in_ready0", int'(in_ready0), 1);
        chk("reset in_ready1", int'(in_ready1), 1);
        chk("reset out_idx0", int'(oi0), 0);
        chk("reset out_last1", int'(ol1), 0);
        @(negedge clk);
        rst = 1'b0;

        send(8'hA4); drain();
        send(8'h00); drain();

        ready_mode = 2;
        send(8'h12);
        repeat (3) @(negedge clk);
        ready_mode = 0;
        drain();

        send(8'h05); send(8'h11); drain();

        // Vector offered while busy must be ignored.
        send(8'h03);
        @(negedge clk);
        in_valid = 1'b1;
        in_vec   = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        send(8'hF0); drain();

        // Reset in the middle of a scan.
        send(8'hF0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset out_valid0", int'(ov0), 0);
        chk("midreset out_valid1", int'(ov1), 0);
        chk("midreset in_ready1", int'(in_ready1), 1);
        q0.delete();
        q1.delete();
        model_ptr = 0;
        @(negedge clk);
        rst = 1'b0;
        send(8'h01); send(8'h11); drain();

        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            rv = (($urandom % 6) == 0) ? '0 : N'($urandom);
            send(rv);
        end
        drain();
        ready_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
